// File: rtl/ysyx_25060173_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_25060173_pkg : shared op encodings, FSM states and operand-sign helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package ysyx_25060173_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic src1_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic src2_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25060173_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_25060173_addsub : W-bit adder/subtractor; cout_o=1 on subtract means a>=b
// Rev 1.0
// ----------------------------------------------------------------------------
module ysyx_25060173_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};

endmodule
`default_nettype wire

// File: rtl/ysyx_25060173_muldiv.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ysyx_25060173_muldiv : iterative RV M-extension unit (shift-add / restoring)
// Rev 1.0
// ----------------------------------------------------------------------------
module ysyx_25060173_muldiv
  import ysyx_25060173_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int              CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   C_LAST  = CW'(XLEN - 1);
  localparam logic [CW-1:0]   C_ONE   = CW'(1);
  localparam logic [XLEN-1:0] C_X1    = XLEN'(1);
  localparam logic [2*XLEN-1:0] C_P1  = (2*XLEN)'(1);
  localparam logic [XLEN-1:0] C_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            neg_q, neg_d;

  // Accept-time operand decode: magnitudes, result sign, special cases
  logic            s1_neg, s2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;

  assign s1_neg   = src1_signed(op) & src1[XLEN-1];
  assign s2_neg   = src2_signed(op) & src2[XLEN-1];
  assign mag1     = s1_neg ? (~src1 + C_X1) : src1;
  assign mag2     = s2_neg ? (~src2 + C_X1) : src2;
  assign div_zero = op[2] & (src2 == '0);
  assign div_ovf  = op[2] & ~op[0] & (src1 == C_MIN) & (src2 == '1);

  // One radix-2 step: acc/lo form the product pair or the remainder/quotient pair
  logic [XLEN:0]   shifted, as_a, as_b, as_sum, mul_nxt;
  logic            as_cout;
  logic [XLEN-1:0] iter_acc, iter_lo;

  assign shifted = {acc_q, lo_q[XLEN-1]};
  assign as_a    = op_q[2] ? shifted : {1'b0, acc_q};
  assign as_b    = {1'b0, opa_q};

  ysyx_25060173_addsub #(
    .W (XLEN + 1)
  ) u_addsub (
    .a_i    (as_a),
    .b_i    (as_b),
    .sub_i  (op_q[2]),
    .sum_o  (as_sum),
    .cout_o (as_cout)
  );

  assign mul_nxt  = lo_q[0] ? as_sum : {1'b0, acc_q};
  assign iter_acc = op_q[2] ? (as_cout ? as_sum[XLEN-1:0] : shifted[XLEN-1:0])
                            : mul_nxt[XLEN:1];
  assign iter_lo  = op_q[2] ? {lo_q[XLEN-2:0], as_cout}
                            : {mul_nxt[0], lo_q[XLEN-1:1]};

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   dv_sel, dv_s, fin;

  assign prod   = {iter_acc, iter_lo};
  assign prod_s = neg_q ? (~prod + C_P1) : prod;
  assign dv_sel = op_q[1] ? iter_acc : iter_lo;
  assign dv_s   = neg_q ? (~dv_sel + C_X1) : dv_sel;
  assign fin    = op_q[2]           ? dv_s :
                  (op_q == MD_MUL)  ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    neg_d   = neg_q;
    res_d   = res_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      res_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d  = op;
            cnt_d = '0;
            acc_d = '0;
            neg_d = (op == MD_REM) ? s1_neg : (s1_neg ^ s2_neg);
            lo_d  = op[2] ? mag1 : mag2;
            opa_d = op[2] ? mag2 : mag1;
            if (div_zero) begin
              state_d = ST_DONE;
              res_d   = op[1] ? src1 : '1;
            end else if (div_ovf) begin
              state_d = ST_DONE;
              res_d   = op[1] ? '0 : src1;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = iter_acc;
          lo_d  = iter_lo;
          if (cnt_q == C_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
            res_d   = fin;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060173_muldiv.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ysyx_25060173_muldiv : vector table, random ops vs. arithmetic model, corners
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ysyx_25060173_muldiv;
  import ysyx_25060173_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_25060173_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RISC-V M-extension definitions
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = longint'({32'b0, a});
    longint unsigned ub = longint'({32'b0, b});
    logic [63:0]     p;
    case (o)
      MD_MUL:    begin p = sa * sb; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      MD_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MINV;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Latency counts edges from the accept edge (inclusive) to the one raising out_valid
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[16];

  initial begin
    logic [31:0] r;
    int          lat;
    bit          seen;

    vecs[0]  = '{MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[3]  = '{MD_MULH,   MINV,         MINV,          32'h4000_0000, 33};
    vecs[4]  = '{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{MD_DIVU,   32'd100,      32'd7,         32'd14,        33};
    vecs[7]  = '{MD_REMU,   32'd100,      32'd7,         32'd2,         33};
    vecs[8]  = '{MD_DIV,    32'd5,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{MD_REMU,   32'd5,        32'd0,         32'd5,         1};
    vecs[10] = '{MD_DIV,    MINV,         32'hFFFF_FFFF, MINV,          1};
    vecs[11] = '{MD_REM,    MINV,         32'hFFFF_FFFF, 32'h0,         1};
    vecs[12] = '{MD_DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{MD_REM,    32'd5,        32'd0,         32'd5,         1};
    vecs[14] = '{MD_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 33};
    vecs[15] = '{MD_MULHU,  32'h1234_5678, 32'h10,        32'h1,         33};

    // Outputs under reset
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, r, lat);
      check($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), r, model(ro, ra, rb));
      check($sformatf("rand%0d_latency", i), lat, model_lat(ro, ra, rb));
    end

    // Back-pressure: result held, busy inputs ignored
    out_ready = 1'b0;
    run_op(MD_DIVU, 32'd100, 32'd7, r, lat);
    check("bp_result", r, 14);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      check($sformatf("bp_hold_%0d", i), result, 14);
      op = MD_DIV; src1 = 32'd5; src2 = 32'd0; in_valid = (i % 2 == 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    run_op(MD_REMU, 32'd100, 32'd7, r, lat);
    check("bp_after_result", r, 2);

    // Flush on CALC cycle 5
    op = MD_MUL; src1 = 32'd7; src2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", seen, 0);
    run_op(MD_DIVU, 32'd9, 32'd3, r, lat);
    check("post_flush_result", r, 3);
    check("post_flush_latency", lat, 33);

    // Flush together with a request in IDLE must not accept it
    op = MD_DIV; src1 = 32'd5; src2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_out_valid", out_valid, 0);
    check("flush_accept_in_ready", in_ready, 1);

    // Reset during CALC
    op = MD_MUL; src1 = 32'd123; src2 = 32'd456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_calc_in_ready", in_ready, 1);
    check("rst_calc_out_valid", out_valid, 0);
    check("rst_calc_result", result, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(MD_DIVU, 32'd100, 32'd7, r, lat);
    check("rst_first_accept_result", r, 14);
    check("rst_first_accept_latency", lat, 33);

    // Reset during DONE
    out_ready = 1'b0;
    run_op(MD_MUL, 32'd6, 32'd7, r, lat);
    check("rst_done_pre_result", r, 42);
    rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_result", result, 0);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_done_idle", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
